twiddle_addr_gen: RTL and testbench

- Generates the per-sample twiddle number for one R2^2 SDF stage.
- Sits directly upstream of the 1/8-table twiddle converter/ROM: its tw_addr output drives that stage's twiddle number input, aligned with the stage's data stream.
- Uses a multiplier-free accumulator: tw_addr = m(q) * j, where q is the sample's quadrant and j its index within the quadrant.

---
 rtl/twiddle_addr_gen.sv | 91 +++++++++
 tb/tb_twiddle_addr_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/twiddle_addr_gen.sv
// Twiddle-number generator for one R2^2 SDF stage: tw_addr = m(q) * j, built with an adder only.
// Define TW_ADDR_CHECK_EN to build a reference-multiplier checker that drives the sticky tw_err flag.
module twiddle_addr_gen #(
    parameter int LOG_N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_sync,
    input  logic             di_en,
    output logic [LOG_N-1:0] tw_addr,
    output logic             tw_en,
    output logic             tw_last,
    output logic             tw_err
);
    localparam int JW = LOG_N - 2;

    logic [LOG_N-1:0] di_count_reg;
    logic [LOG_N-1:0] acc_reg;
    logic [LOG_N-1:0] k;
    logic [LOG_N-1:0] acc_next;
    logic [1:0]       q;
    logic [1:0]       m;
    logic [JW-1:0]    j;

    always_comb begin
        k = di_sync ? '0 : di_count_reg;
        q = k[LOG_N-1 -: 2];
        j = k[JW-1:0];
    end

    // m(q) is simply q with its two bits swapped (bit-reversed quadrant order).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mrev
            assign m[gi] = q[1-gi];
        end
    endgenerate

    always_comb begin
        acc_next = (j == '0) ? '0 : acc_reg + {{JW{1'b0}}, m};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            di_count_reg <= '0;
            acc_reg      <= '0;
            tw_addr      <= '0;
            tw_en        <= 1'b0;
            tw_last      <= 1'b0;
        end else if (di_en) begin
            di_count_reg <= k + LOG_N'(1);
            acc_reg      <= acc_next;
            tw_addr      <= acc_next;
            tw_en        <= 1'b1;
            tw_last      <= &k;
        end else begin
            tw_en   <= 1'b0;
            tw_last <= 1'b0;
            if (di_sync) begin
                di_count_reg <= '0;
                acc_reg      <= '0;
            end
        end
    end

`ifdef TW_ADDR_CHECK_EN
    logic [LOG_N-1:0] ref_next;
    logic [LOG_N-1:0] ref_reg;

    always_comb begin
        ref_next = {{JW{1'b0}}, m} * {2'b00, j};
    end

    // The reference is registered with tw_addr so both are compared in the tw_en cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_reg <= '0;
            tw_err  <= 1'b0;
        end else begin
            if (di_en) begin
                ref_reg <= ref_next;
            end
            if (tw_en && (tw_addr != ref_reg)) begin
                tw_err <= 1'b1;
            end
        end
    end
`else
    assign tw_err = 1'b0;
`endif

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Scoreboard bench for twiddle_addr_gen at LOG_N=4: driver queues hand-computed twiddles, monitor compares.
module tb_twiddle_addr_gen;
    localparam int LOG_N = 4;
    localparam int N     = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             di_sync = 1'b0;
    logic             di_en = 1'b0;
    logic [LOG_N-1:0] tw_addr;
    logic             tw_en;
    logic             tw_last;
    logic             tw_err;

    twiddle_addr_gen #(.LOG_N(LOG_N)) dut (
        .clock   (clock),
        .reset   (reset),
        .di_sync (di_sync),
        .di_en   (di_en),
        .tw_addr (tw_addr),
        .tw_en   (tw_en),
        .tw_last (tw_last),
        .tw_err  (tw_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [LOG_N-1:0] addr;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   kcnt     = 0;
    int   exp_frame[N] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    bit   mon_off  = 1'b0;
    bit   hold_chk = 1'b0;
    logic [LOG_N-1:0] last_addr = '0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One sample slot: inputs change 1 ns after the rising edge.
    task automatic send(input bit sync, input bit en, input bit push);
        int k;
        @(posedge clock);
        #1;
        di_sync = sync;
        di_en   = en;
        if (en) begin
            k = sync ? 0 : kcnt;
            if (push) exp_q.push_back('{addr: LOG_N'(exp_frame[k]), last: (k == N-1)});
            kcnt = (k + 1) % N;
        end else if (sync) begin
            kcnt = 0;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && !mon_off) begin
            if (tw_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tw_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tw_addr", int'(tw_addr), int'(e.addr));
                    chk("tw_last", int'(tw_last), int'(e.last));
                    chk("tw_err_clean", int'(tw_err), 0);
                    $display("txn: tw_addr=%0d tw_last=%0d", tw_addr, tw_last);
                end
                last_addr = tw_addr;
            end else if (hold_chk) begin
                chk("tw_addr_hold", int'(tw_addr), int'(last_addr));
            end
        end
    end

    task automatic drain();
        repeat (4) @(posedge clock);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2;
        chk("rst_tw_addr", int'(tw_addr), 0);
        chk("rst_tw_en", int'(tw_en), 0);
        chk("rst_tw_last", int'(tw_last), 0);
        chk("rst_tw_err", int'(tw_err), 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Full frame started with di_sync.
        send(1, 1, 1);
        for (int i = 1; i < N; i++) send(0, 1, 1);
        send(0, 0, 0);
        drain();

        // Bubbles every other cycle; tw_addr must hold through gaps.
        hold_chk = 1'b1;
        send(1, 1, 1);
        for (int i = 1; i < N; i++) begin
            send(0, 0, 0);
            send(0, 1, 1);
        end
        send(0, 0, 0);
        drain();
        hold_chk = 1'b0;

        // Two back-to-back frames with no di_sync.
        for (int i = 0; i < 2 * N; i++) send(0, 1, 1);
        send(0, 0, 0);
        drain();

        // di_sync mid-frame at k=6 restarts the sequence.
        for (int i = 0; i < 6; i++) send(0, 1, 1);
        send(1, 1, 1);
        for (int i = 1; i < N; i++) send(0, 1, 1);
        send(0, 0, 0);
        drain();

        // Asynchronous reset right after the k=9 twiddle (value 1) appears.
        for (int i = 0; i < 9; i++) send(0, 1, 1);
        send(0, 1, 0);
        send(0, 0, 0);
        #1;
        chk("pre_reset_tw_addr", int'(tw_addr), 1);
        chk("pre_reset_tw_en", int'(tw_en), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_tw_addr", int'(tw_addr), 0);
        chk("async_rst_tw_en", int'(tw_en), 0);
        kcnt = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < N; i++) send(0, 1, 1);
        send(0, 0, 0);
        drain();
        chk("tw_err_default", int'(tw_err), 0);

`ifdef TW_ADDR_CHECK_EN
        // Corrupt the accumulator: the checker must latch tw_err and keep it.
        mon_off = 1'b1;
        send(1, 1, 0);
        force dut.acc_reg = 4'h5;
        send(0, 1, 0);
        send(0, 0, 0);
        release dut.acc_reg;
        repeat (2) @(posedge clock);
        #1 chk("tw_err_set", int'(tw_err), 1);
        repeat (5) @(posedge clock);
        #1 chk("tw_err_sticky", int'(tw_err), 1);
        reset = 1'b1;
        #1 chk("tw_err_cleared", int'(tw_err), 0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
